// File: rtl/filter_accel_udiv_ibs.sv
// 18/10-bit unsigned restoring divider producing an 8-bit quotient, one bit per clock.
// Optional remainder output is built when FILTER_ACCEL_UDIV_REM_EN is defined.
module filter_accel_udiv_ibs #(
  parameter int unsigned ID         = 32'd1,
  parameter int unsigned din0_WIDTH = 32'd18,
  parameter int unsigned din1_WIDTH = 32'd10,
  parameter int unsigned dout_WIDTH = 32'd8
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst,
  input  logic                  start,
  input  logic [din0_WIDTH-1:0] din0,
  input  logic [din1_WIDTH-1:0] din1,
  output logic                  busy,
  output logic                  done,
  output logic [dout_WIDTH-1:0] dout,
  output logic [din1_WIDTH-1:0] rem,
  output logic                  ovf
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]            r_state;
  logic [din0_WIDTH-1:0] r_part;
  logic [din1_WIDTH-1:0] r_div;
  logic [2:0]            r_cnt;
  logic [dout_WIDTH-1:0] r_quot;
  logic [dout_WIDTH-1:0] r_dout;
  logic                  r_ovf;

  logic                  w_accept;
  logic                  w_ovf_in;
  logic                  w_last;
  logic [din0_WIDTH-1:0] w_trial;
  logic                  w_ge;
  logic [din0_WIDTH-1:0] w_part_nxt;
  logic [dout_WIDTH-1:0] w_quot_nxt;

  assign w_accept = start && (r_state != CALC);
  // Quotient overflows 8 bits exactly when din0 >= din1 * 256.
  assign w_ovf_in = (din1 == '0) || (din0 >= {din1, 8'd0});
  assign w_last   = (r_state == CALC) && (r_cnt == 3'd0);

  assign w_trial    = din0_WIDTH'(r_div) << r_cnt;
  assign w_ge       = (r_part >= w_trial);
  assign w_part_nxt = w_ge ? (r_part - w_trial) : r_part;
  assign w_quot_nxt = r_quot | (dout_WIDTH'(w_ge) << r_cnt);

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      r_state <= IDLE;
      r_part  <= '0;
      r_div   <= '0;
      r_cnt   <= '0;
      r_quot  <= '0;
      r_dout  <= '0;
      r_ovf   <= 1'b0;
    end else begin
      case (r_state)
        IDLE, DONE: begin
          if (start) begin
            r_part <= din0;
            r_div  <= din1;
            r_quot <= '0;
            if (w_ovf_in) begin
              r_ovf   <= 1'b1;
              r_dout  <= '1;
              r_state <= DONE;
            end else begin
              r_ovf   <= 1'b0;
              r_cnt   <= 3'd7;
              r_state <= CALC;
            end
          end else begin
            r_state <= IDLE;
          end
        end
        CALC: begin
          r_part <= w_part_nxt;
          r_quot <= w_quot_nxt;
          r_cnt  <= r_cnt - 3'd1;
          if (r_cnt == 3'd0) begin
            r_dout  <= w_quot_nxt;
            r_state <= DONE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

`ifdef FILTER_ACCEL_UDIV_REM_EN
  logic [din1_WIDTH-1:0] r_rem;

  // Final partial remainder is below the divisor, so its low 10 bits are exact.
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      r_rem <= '0;
    end else if (w_accept && w_ovf_in) begin
      r_rem <= '0;
    end else if (w_last) begin
      r_rem <= w_part_nxt[din1_WIDTH-1:0];
    end
  end

  assign rem = r_rem;
`else
  assign rem = '0;
`endif

  assign busy = (r_state == CALC);
  assign done = (r_state == DONE);
  assign dout = r_dout;
  assign ovf  = r_ovf;

endmodule

// File: tb/tb_filter_accel_udiv_ibs.sv
// Directed bench for filter_accel_udiv_ibs: latency, quotient/remainder, overflow,
// back-to-back starts, ignored mid-operation starts and asynchronous reset.
module tb_filter_accel_udiv_ibs;

  logic        ap_clk = 1'b0;
  logic        ap_rst = 1'b1;
  logic        start  = 1'b0;
  logic [17:0] din0   = '0;
  logic [9:0]  din1   = '0;
  logic        busy;
  logic        done;
  logic [7:0]  dout;
  logic [9:0]  rem;
  logic        ovf;

  int n_tests = 0;
  int n_fail  = 0;

  filter_accel_udiv_ibs dut (
    .ap_clk (ap_clk),
    .ap_rst (ap_rst),
    .start  (start),
    .din0   (din0),
    .din1   (din1),
    .busy   (busy),
    .done   (done),
    .dout   (dout),
    .rem    (rem),
    .ovf    (ovf)
  );

  always #5 ap_clk = ~ap_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Called away from the clock edge; returns at #1 after the edge that raised done.
  task automatic run_div(input string tag, input logic [17:0] a, input logic [9:0] b,
                         input logic [7:0] exp_q, input logic [9:0] exp_r,
                         input logic exp_ovf, input bit inject);
    int cyc;
    int nbusy;
    int exp_lat;
    logic [9:0] er;
`ifdef FILTER_ACCEL_UDIV_REM_EN
    er = exp_r;
`else
    er = 10'd0;
`endif
    exp_lat = exp_ovf ? 1 : 9;
    din0  = a;
    din1  = b;
    start = 1'b1;
    @(posedge ap_clk);
    #1;
    start = 1'b0;
    cyc   = 1;
    nbusy = 0;
    while (!done && cyc < 20) begin
      if (busy) nbusy++;
      if (inject && cyc == 3) begin
        start = 1'b1;
        din0  = 18'd50;
        din1  = 10'd3;
      end
      if (inject && cyc == 4) start = 1'b0;
      @(posedge ap_clk);
      #1;
      cyc++;
    end
    start = 1'b0;
    check({tag, ".done"}, 32'(done), 32'd1);
    check({tag, ".lat"}, cyc, exp_lat);
    check({tag, ".busy_cycles"}, nbusy, exp_lat - 1);
    check({tag, ".dout"}, 32'(dout), 32'(exp_q));
    check({tag, ".rem"}, 32'(rem), 32'(er));
    check({tag, ".ovf"}, 32'(ovf), 32'(exp_ovf));
  endtask

  initial begin
    int ndone;
    logic [7:0] ra;
    logic [9:0] rb;

    repeat (2) @(posedge ap_clk);
    #1;
    check("rst.busy", 32'(busy), 32'd0);
    check("rst.done", 32'(done), 32'd0);
    check("rst.dout", 32'(dout), 32'd0);
    check("rst.rem", 32'(rem), 32'd0);
    check("rst.ovf", 32'(ovf), 32'd0);
    @(negedge ap_clk);
    ap_rst = 1'b0;

    run_div("d200_10", 18'd200, 10'd10, 8'd20, 10'd0, 1'b0, 1'b0);
    repeat (2) @(posedge ap_clk);
    #1;
    run_div("d2559_10", 18'd2559, 10'd10, 8'd255, 10'd9, 1'b0, 1'b0);
    run_div("d2560_10", 18'd2560, 10'd10, 8'hFF, 10'd0, 1'b1, 1'b0);
    run_div("d1234_0", 18'd1234, 10'd0, 8'hFF, 10'd0, 1'b1, 1'b0);
    repeat (3) @(posedge ap_clk);
    #1;
    run_div("inject", 18'd1000, 10'd7, 8'd142, 10'd6, 1'b0, 1'b1);
    run_div("d0_5", 18'd0, 10'd5, 8'd0, 10'd0, 1'b0, 1'b0);
    run_div("dmax_1023", 18'd262143, 10'd1023, 8'hFF, 10'd0, 1'b1, 1'b0);
    run_div("d260865_1023", 18'd260865, 10'd1023, 8'd255, 10'd0, 1'b0, 1'b0);

    // Results must hold through idle cycles.
    repeat (3) @(posedge ap_clk);
    #1;
    check("hold.done", 32'(done), 32'd0);
    check("hold.dout", 32'(dout), 32'd255);
    check("hold.ovf", 32'(ovf), 32'd0);

    // Round trip, each start raised in the previous DONE cycle.
    for (int i = 0; i < 5; i++) begin
      ra = 8'($urandom_range(0, 255));
      rb = 10'($urandom_range(1, 1023));
      run_div($sformatf("rt%0d", i), 18'(ra) * 18'(rb), rb, ra, 10'd0, 1'b0, 1'b0);
    end

    run_div("pre_rst", 18'd2559, 10'd10, 8'd255, 10'd9, 1'b0, 1'b0);
    repeat (2) @(posedge ap_clk);
    #1;
    din0  = 18'd200;
    din1  = 10'd10;
    start = 1'b1;
    @(posedge ap_clk);
    #1;
    start = 1'b0;
    repeat (3) @(posedge ap_clk);
    #1;
    ap_rst = 1'b1;
    #1;
    check("midrst.busy", 32'(busy), 32'd0);
    check("midrst.done", 32'(done), 32'd0);
    check("midrst.dout", 32'(dout), 32'd0);
    check("midrst.rem", 32'(rem), 32'd0);
    check("midrst.ovf", 32'(ovf), 32'd0);
    #2;
    ap_rst = 1'b0;
    ndone = 0;
    for (int i = 0; i < 15; i++) begin
      @(posedge ap_clk);
      #1;
      if (done) ndone++;
    end
    check("midrst.no_done", ndone, 0);
    run_div("post_rst", 18'd1000, 10'd7, 8'd142, 10'd6, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
